// File: rtl/imm_mov_sequencer.sv
// imm_mov_sequencer
//
// Turns a 64-bit constant and a destination register into the LEGv8
// MOVZ/MOVK instruction sequence that builds that constant. One 32-bit
// instruction word is issued per output handshake, in ascending halfword
// order. The first word is always MOVZ and every later word is MOVK.
//
// Ports:
//   CLK        clock, rising edge
//   resetl     asynchronous active-low reset
//   in_valid   request present on in_value / in_rd
//   in_ready   block is idle and can take a request
//   in_value   64-bit constant to materialise
//   in_rd      destination register number (31 passes through unchanged)
//   out_valid  out_instr holds a word of the current sequence
//   out_ready  consumer takes out_instr this cycle
//   out_instr  {opcode[8:0], hw[1:0], imm16[15:0], rd[4:0]}
//   out_last   out_instr is the final word of the sequence
//   out_count  number of words in the current sequence (1..4)

module imm_mov_sequencer #(
    parameter logic [8:0] OPC_MOVZ  = 9'b110100101,
    parameter logic [8:0] OPC_MOVK  = 9'b111100101,
    parameter bit         SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic [2:0]  out_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [63:0] value_q;
    logic [4:0]  rd_q;
    logic [3:0]  mask_q;
    logic [1:0]  hw_q;

    // Halfwords to emit. A zero constant still needs one MOVZ of hw0.
    function automatic logic [3:0] emit_mask(input logic [63:0] v);
        logic [3:0] nz;
        for (int i = 0; i < 4; i++) begin
            nz[i] = |v[16*i +: 16];
        end
        if (!SKIP_ZERO) begin
            return 4'b1111;
        end
        if (nz == 4'b0000) begin
            return 4'b0001;
        end
        return nz;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Mask bits strictly above halfword hw; empty for hw=3, so hw never wraps.
    function automatic logic [3:0] bits_above(input logic [3:0] m, input logic [1:0] hw);
        return m & (4'b1110 << hw);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] hw);
        return v[16*hw +: 16];
    endfunction

    logic [3:0] acc_mask;
    logic [1:0] acc_hw;
    logic [2:0] acc_count;
    logic [1:0] next_hw;
    logic       next_last;

    assign acc_mask  = emit_mask(in_value);
    assign acc_hw    = lowest_set(acc_mask);
    assign acc_count = popcount4(acc_mask);
    assign next_hw   = lowest_set(bits_above(mask_q, hw_q));
    assign next_last = (bits_above(mask_q, next_hw) == 4'b0000);

    // Handshake flags are straight decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            value_q   <= '0;
            rd_q      <= '0;
            mask_q    <= '0;
            hw_q      <= '0;
            out_instr <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value_q   <= in_value;
                        rd_q      <= in_rd;
                        mask_q    <= acc_mask;
                        hw_q      <= acc_hw;
                        out_instr <= {OPC_MOVZ, acc_hw, halfword(in_value, acc_hw), in_rd};
                        out_last  <= (acc_count == 3'd1);
                        out_count <= acc_count;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    // Word is held until the consumer takes it.
                    if (out_ready) begin
                        if (out_last) begin
                            out_last  <= 1'b0;
                            out_count <= '0;
                            state     <= IDLE;
                        end else begin
                            hw_q      <= next_hw;
                            out_instr <= {OPC_MOVK, next_hw, halfword(value_q, next_hw), rd_q};
                            out_last  <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_mov_sequencer.sv
module tb_imm_mov_sequencer;

    localparam logic [8:0] MZ = 9'b110100101;
    localparam logic [8:0] MK = 9'b111100101;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic [2:0]  count;
    } exp_t;

    logic        CLK = 1'b0;
    logic        resetl = 1'b1;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic [63:0] in_value = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0;
    logic        rdy0, rdy1, ov0, ov1, last0, last1;
    logic [31:0] instr0, instr1;
    logic [2:0]  cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc0 = 0, acc1 = 0;
    int acc_cyc0 = 0;
    bit rnd_ready = 1'b0;

    exp_t        q0[$], q1[$];
    logic [31:0] log0[$], log1[$];
    int          hs_cyc0[$];

    imm_mov_sequencer #(.SKIP_ZERO(1'b1)) dut0 (
        .CLK(CLK), .resetl(resetl), .in_valid(iv0), .in_ready(rdy0),
        .in_value(in_value), .in_rd(in_rd), .out_valid(ov0), .out_ready(out_ready),
        .out_instr(instr0), .out_last(last0), .out_count(cnt0)
    );

    imm_mov_sequencer #(.SKIP_ZERO(1'b0)) dut1 (
        .CLK(CLK), .resetl(resetl), .in_valid(iv1), .in_ready(rdy1),
        .in_value(in_value), .in_rd(in_rd), .out_valid(ov1), .out_ready(out_ready),
        .out_instr(instr1), .out_last(last1), .out_count(cnt1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: expected word list for a request, from the encoding rules.
    task automatic push_seq(input int id, input logic [63:0] v, input logic [4:0] rd, input bit skip);
        logic [3:0] m;
        int n, k;
        exp_t e;
        for (int i = 0; i < 4; i++) m[i] = (((v >> (16 * i)) & 64'hFFFF) != 0);
        if (!skip) m = 4'hF;
        else if (m == 4'h0) m = 4'h1;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.instr = {(k == 0) ? MZ : MK, 2'(i), 16'(v >> (16 * i)), rd};
                e.last  = (k == n - 1);
                e.count = 3'(n);
                if (id == 0) q0.push_back(e);
                else q1.push_back(e);
                k++;
            end
        end
    endtask

    // Monitor: consumes handshaken words and records accepted requests.
    always @(posedge CLK) begin
        if (!resetl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ov0 && out_ready && q0.size() != 0) begin
                log0.push_back(instr0);
                hs_cyc0.push_back(cyc);
                void'(q0.pop_front());
            end
            if (ov1 && out_ready && q1.size() != 0) begin
                log1.push_back(instr1);
                void'(q1.pop_front());
            end
            if (iv0 && rdy0) begin
                push_seq(0, in_value, in_rd, 1'b1);
                acc0++;
                acc_cyc0 = cyc;
            end
            if (iv1 && rdy1) begin
                push_seq(1, in_value, in_rd, 1'b0);
                acc1++;
            end
        end
        cyc++;
    end

    task automatic cmp_dut(input int id, input logic v, input logic r, input logic [31:0] ins,
                           input logic l, input logic [2:0] c);
        int n;
        exp_t e;
        n = (id == 0) ? q0.size() : q1.size();
        chk($sformatf("out_valid%0d", id), {63'b0, v}, {63'b0, n != 0});
        chk($sformatf("in_ready%0d", id), {63'b0, r}, {63'b0, n == 0});
        if (n != 0 && v) begin
            e = (id == 0) ? q0[0] : q1[0];
            chk($sformatf("out_instr%0d", id), {32'b0, ins}, {32'b0, e.instr});
            chk($sformatf("out_last%0d", id), {63'b0, l}, {63'b0, e.last});
            chk($sformatf("out_count%0d", id), {61'b0, c}, {61'b0, e.count});
        end
    endtask

    task automatic cmp_reset(input int id, input logic v, input logic r, input logic [31:0] ins,
                             input logic l, input logic [2:0] c);
        chk($sformatf("rst_valid%0d", id), {63'b0, v}, 64'd0);
        chk($sformatf("rst_ready%0d", id), {63'b0, r}, 64'd1);
        chk($sformatf("rst_instr%0d", id), {32'b0, ins}, 64'd0);
        chk($sformatf("rst_last%0d", id), {63'b0, l}, 64'd0);
        chk($sformatf("rst_count%0d", id), {61'b0, c}, 64'd0);
    endtask

    // Per-cycle compare against the reference queues.
    always @(negedge CLK) begin
        if (!resetl) begin
            cmp_reset(0, ov0, rdy0, instr0, last0, cnt0);
            cmp_reset(1, ov1, rdy1, instr1, last1, cnt1);
        end else begin
            cmp_dut(0, ov0, rdy0, instr0, last0, cnt0);
            cmp_dut(1, ov1, rdy1, instr1, last1, cnt1);
        end
    end

    always @(negedge CLK) begin
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [63:0] v, input logic [4:0] rd);
        int a0, a1;
        a0 = acc0;
        a1 = acc1;
        in_value = v;
        in_rd = rd;
        iv0 = 1'b1;
        iv1 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (acc0 != a0) iv0 = 1'b0;
            if (acc1 != a1) iv1 = 1'b0;
            if (!iv0 && !iv1) break;
        end
        if (iv0 || iv1) begin
            chk("accept_timeout", {62'b0, iv0, iv1}, 64'd0);
            iv0 = 1'b0;
            iv1 = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov0 || ov1) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        hs_cyc0.delete();
    endtask

    initial begin
        logic [31:0] held;
        logic        held_last;
        logic [63:0] v;

        #1 resetl = 1'b0;
        repeat (3) @(negedge CLK);
        resetl = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);

        // Zero constant
        clear_logs();
        send(64'h0, 5'd3);
        drain();
        chk("zero_words", 64'(log0.size()), 64'd1);
        chk("zero_word0", {32'b0, log0[0]}, 64'hD2800003);
        chk("zero_noskip_words", 64'(log1.size()), 64'd4);
        chk("zero_ready_again", {63'b0, rdy0}, 64'd1);

        // Single middle halfword
        clear_logs();
        send(64'h0000_0000_0001_0000, 5'd1);
        drain();
        chk("mid_words", 64'(log0.size()), 64'd1);
        chk("mid_word0", {32'b0, log0[0]}, 64'hD2A00021);

        // Sparse constant, latency and no bubble
        clear_logs();
        send(64'h1234_0000_0000_ABCD, 5'd2);
        drain();
        chk("sparse_words", 64'(log0.size()), 64'd2);
        chk("sparse_word0", {32'b0, log0[0]}, 64'hD29579A2);
        chk("sparse_word1", {32'b0, log0[1]}, 64'hF2E24682);
        chk("sparse_latency", 64'(hs_cyc0[0] - acc_cyc0), 64'd1);
        chk("sparse_nobubble", 64'(hs_cyc0[1] - hs_cyc0[0]), 64'd1);

        // Dense constant, backpressure on word 2, in_valid ignored while busy
        clear_logs();
        out_ready = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        held = instr0;
        held_last = last0;
        in_value = 64'h0000_0000_0000_0042;
        in_rd = 5'd7;
        iv0 = 1'b1;
        iv1 = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_instr_hold", {32'b0, instr0}, {32'b0, held});
            chk("bp_last_hold", {63'b0, last0}, {63'b0, held_last});
            chk("bp_ready_low", {63'b0, rdy0}, 64'd0);
        end
        iv0 = 1'b0;
        iv1 = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("dense_words", 64'(log0.size()), 64'd4);
        chk("dense_word0", {32'b0, log0[0]}, 64'hD29FFFFF);
        for (int i = 1; i < 4; i++) begin
            chk("dense_hw", {62'b0, log0[i][22:21]}, 64'(i));
            chk("dense_opc", {55'b0, log0[i][31:23]}, {55'b0, MK});
        end

        // All four halfwords emitted when zero skipping is off
        clear_logs();
        send(64'h5, 5'd0);
        drain();
        chk("noskip_words", 64'(log1.size()), 64'd4);
        chk("noskip_w0", {32'b0, log1[0]}, 64'hD28000A0);
        chk("noskip_w1", {32'b0, log1[1]}, 64'hF2A00000);
        chk("noskip_w2", {32'b0, log1[2]}, 64'hF2C00000);
        chk("noskip_w3", {32'b0, log1[3]}, 64'hF2E00000);
        chk("skip_w0", {32'b0, log0[0]}, 64'hD28000A0);

        // Reset during word 2 of the sparse case
        out_ready = 1'b0;
        send(64'h1234_0000_0000_ABCD, 5'd2);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        @(posedge CLK);
        #2 resetl = 1'b0;
        #1;
        chk("midrst_valid0", {63'b0, ov0}, 64'd0);
        chk("midrst_ready0", {63'b0, rdy0}, 64'd1);
        chk("midrst_valid1", {63'b0, ov1}, 64'd0);
        chk("midrst_ready1", {63'b0, rdy1}, 64'd1);
        q0.delete();
        q1.delete();
        @(negedge CLK);
        @(negedge CLK);
        resetl = 1'b1;
        clear_logs();
        out_ready = 1'b1;
        @(negedge CLK);
        chk("postrst_idle", {63'b0, ov0}, 64'd0);
        send(64'h0000_0000_00FF_0000, 5'd4);
        drain();
        chk("postrst_words", 64'(log0.size()), 64'd1);
        chk("postrst_word0", {32'b0, log0[0]}, 64'hD2A01FE4);

        // Randomized back-to-back requests with random backpressure
        rnd_ready = 1'b1;
        for (int r = 0; r < 150; r++) begin
            v = '0;
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 1) != 0) v[16*h +: 16] = 16'($urandom);
            end
            send(v, 5'($urandom_range(0, 31)));
        end
        drain();
        rnd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
